// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a pending-writeback scoreboard.
//
// After reset, an init sweep writes RESET_VAL into x1..x(NUM_REGS-1), one register
// per cycle. This keeps the storage free of reset logic so it can map to distributed
// RAM. init_done rises once the sweep has finished. During the sweep, reads return 0
// and writes and issues are ignored.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; restarts the init sweep
//   rd_addr     per read port: register index
//   rd_data     per read port: combinational read data (optional write bypass)
//   rd_pending  per read port: scoreboard bit for rd_addr
//   wr_en       per write port: write enable
//   wr_addr     per write port: register index
//   wr_data     per write port: data
//   iss_valid   marks iss_rd pending at this edge
//   iss_rd      destination register being issued
//   init_done   1 once the sweep is complete
module regfile_mp #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     NUM_REGS  = 32,
    parameter int unsigned     NUM_RD    = 2,
    parameter int unsigned     NUM_WR    = 2,
    parameter bit              BYPASS    = 1'b1,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_RD-1:0][$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]            rd_data,
    output logic [NUM_RD-1:0]                      rd_pending,
    input  logic [NUM_WR-1:0]                      wr_en,
    input  logic [NUM_WR-1:0][$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]            wr_data,
    input  logic                                   iss_valid,
    input  logic [$clog2(NUM_REGS)-1:0]            iss_rd,
    output logic                                   init_done
);

    localparam int unsigned     AW       = $clog2(NUM_REGS);
    localparam logic [AW-1:0]   LAST_IDX = AW'(NUM_REGS - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic              run;

    assign run = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            idx       <= AW'(1);
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (idx == LAST_IDX) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; x0 is never written and is masked on read.
    // Later write ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                regs[idx] <= RESET_VAL;
            end else begin
                for (int unsigned k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && (wr_addr[k] != '0)) begin
                        regs[wr_addr[k]] <= wr_data[k];
                    end
                end
            end
        end
    end

    // The set is applied after the clears, so issue beats writeback on the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else if (run) begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (wr_en[k]) begin
                    pending[wr_addr[k]] <= 1'b0;
                end
            end
            if (iss_valid && (iss_rd != '0)) begin
                pending[iss_rd] <= 1'b1;
            end
        end
    end

    always_comb begin
        logic            hit;
        logic [XLEN-1:0] byp;
        hit        = 1'b0;
        byp        = '0;
        rd_data    = '0;
        rd_pending = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            hit = 1'b0;
            byp = '0;
            if (BYPASS) begin
                for (int unsigned k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && (wr_addr[k] != '0) && (wr_addr[k] == rd_addr[p])) begin
                        hit = 1'b1;
                        byp = wr_data[k];
                    end
                end
            end
            if (run && (rd_addr[p] != '0)) begin
                rd_data[p]    = hit ? byp : regs[rd_addr[p]];
                rd_pending[p] = pending[rd_addr[p]] & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (32 regs, 2 read ports, 2 write ports, bypass on).
module tb_regfile_mp;

    localparam logic [31:0] R = 32'h0BAD_F00D;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        rd_pending;
    logic [1:0]        wr_en;
    logic [1:0][4:0]   wr_addr;
    logic [1:0][31:0]  wr_data;
    logic              iss_valid;
    logic [4:0]        iss_rd;
    logic              init_done;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(
        .XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
        .BYPASS(1'b1), .RESET_VAL(R)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
        logic        ep0, ep1;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    // Counts edges after reset release until init_done; expects exactly 31.
    // Keeps writes/issues to x4 active throughout to prove they are ignored.
    task automatic wait_init(input string name);
        int cyc = 0;
        wr_en = 2'b11; wr_addr[0] = 5'd4; wr_addr[1] = 5'd3;
        wr_data[0] = 32'h77; wr_data[1] = 32'h66;
        iss_valid = 1'b1; iss_rd = 5'd4;
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd5;
        #1;
        chk({name, "_init_low"}, {31'd0, init_done}, 32'd0);
        chk({name, "_init_rd0"}, rd_data[0], 32'd0);
        chk({name, "_init_pend"}, {30'd0, rd_pending}, 32'd0);
        while (!init_done && cyc < 40) begin
            step();
            cyc++;
        end
        chk({name, "_init_cycles"}, cyc, 32'd31);
        idle();
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0;
        idle();

        // Test 1: full sweep after a one-cycle reset
        step();
        reset = 1'b0;
        wait_init("t1");
        #1;
        for (int r = 0; r < 32; r += 2) begin
            rd_addr[0] = 5'(r); rd_addr[1] = 5'(r + 1);
            #1;
            chk("t1_sweep_even", rd_data[0], (r == 0) ? 32'd0 : R);
            chk("t1_sweep_odd", rd_data[1], R);
        end

        vecs[0]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 5'd0,  5'd1,  32'h0,        R,            1'b0, 1'b0};
        vecs[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 5'd31, 5'd16, R,            R,            1'b0, 1'b0};
        vecs[2]  = '{2'b11, 5'd5,  5'd5,  32'hDEADBEEF, 32'h12345678, 1'b0, 5'd0, 5'd5,  5'd6,  32'h12345678, R,            1'b0, 1'b0};
        vecs[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 5'd5,  5'd5,  32'h12345678, 32'h12345678, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        vecs[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd7, 5'd0,  5'd7,  32'h0,        R,            1'b0, 1'b0};
        vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  R,            R,            1'b1, 1'b1};
        vecs[7]  = '{2'b01, 5'd7,  5'd0,  32'hA5,       32'h0,        1'b0, 5'd0, 5'd7,  5'd8,  32'hA5,       R,            1'b0, 1'b0};
        vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  32'hA5,       32'hA5,       1'b0, 1'b0};
        vecs[9]  = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h1,        1'b1, 5'd9, 5'd9,  5'd9,  32'h1,        32'h1,        1'b0, 1'b0};
        vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  32'h1,        32'h1,        1'b1, 1'b1};
        vecs[11] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd0, 5'd0,  5'd9,  32'h0,        32'h1,        1'b0, 1'b1};
        vecs[12] = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h2,        1'b0, 5'd0, 5'd9,  5'd0,  32'h2,        32'h0,        1'b0, 1'b0};
        vecs[13] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 5'd9,  5'd0,  32'h2,        32'h0,        1'b0, 1'b0};
        vecs[14] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd3, 5'd3,  5'd0,  R,            32'h0,        1'b0, 1'b0};
        vecs[15] = '{2'b11, 5'd10, 5'd11, 32'h11,       32'h22,       1'b0, 5'd0, 5'd10, 5'd11, 32'h11,       32'h22,       1'b0, 1'b0};
        vecs[16] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 5'd10, 5'd3,  32'h11,       R,            1'b0, 1'b1};
        vecs[17] = '{2'b01, 5'd12, 5'd12, 32'hAA,       32'hBB,       1'b0, 5'd0, 5'd12, 5'd11, 32'hAA,       32'h22,       1'b0, 1'b0};
        vecs[18] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 5'd12, 5'd3,  32'hAA,       R,            1'b0, 1'b1};

        // Tests 2-5: table of RUN-mode vectors, outputs checked before each edge
        for (int i = 0; i < 19; i++) begin
            wr_en = vecs[i].we;
            wr_addr[0] = vecs[i].wa0; wr_addr[1] = vecs[i].wa1;
            wr_data[0] = vecs[i].wd0; wr_data[1] = vecs[i].wd1;
            iss_valid = vecs[i].iv; iss_rd = vecs[i].ir;
            rd_addr[0] = vecs[i].ra0; rd_addr[1] = vecs[i].ra1;
            #1;
            chk($sformatf("v%0d_rd0", i), rd_data[0], vecs[i].e0);
            chk($sformatf("v%0d_rd1", i), rd_data[1], vecs[i].e1);
            chk($sformatf("v%0d_pend0", i), {31'd0, rd_pending[0]}, {31'd0, vecs[i].ep0});
            chk($sformatf("v%0d_pend1", i), {31'd0, rd_pending[1]}, {31'd0, vecs[i].ep1});
            step();
        end
        idle();

        // Test 6b: reset in RUN with x3 pending
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_init("t6b");
        rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
        #1;
        chk("t6b_x3_data", rd_data[0], R);
        chk("t6b_x3_pend", {31'd0, rd_pending[0]}, 32'd0);
        chk("t6b_x4_data", rd_data[1], R);
        chk("t6b_x4_pend", {31'd0, rd_pending[1]}, 32'd0);
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd12;
        #1;
        chk("t6b_x5_data", rd_data[0], R);
        chk("t6b_x12_data", rd_data[1], R);

        // Test 6a: reset mid-sweep when idx=10 is being written
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("t6a_mid_low", {31'd0, init_done}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_init("t6a");
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd31;
        #1;
        chk("t6a_x4_data", rd_data[0], R);
        chk("t6a_x31_data", rd_data[1], R);
        chk("t6a_x4_pend", {31'd0, rd_pending[0]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
